// File: rtl/wb_master_sched_if.sv
// Bundle of the scheduler's master-side request lines, slave-side ack and the
// gated bus/ownership outputs that feed the address decoder.
interface wb_master_sched_if;
  localparam int unsigned N_M  = 4;
  localparam int unsigned ID_W = 2;

  logic [N_M-1:0]  m_cyc;
  logic [N_M-1:0]  m_stb;
  logic            s_ack;
  logic            s_cyc;
  logic            s_stb;
  logic [N_M-1:0]  grant;
  logic [ID_W-1:0] grant_id;
  logic [N_M-1:0]  m_ack;
  logic [N_M-1:0]  m_err;
  logic            timeout;
  logic            busy;

  // Scheduler side: consumes requests and ack, drives the gated bus and ownership.
  modport master (
    input  m_cyc, m_stb, s_ack,
    output s_cyc, s_stb, grant, grant_id, m_ack, m_err, timeout, busy
  );

  // Environment side: masters and slave drive requests/ack, observe the scheduler.
  modport slave (
    output m_cyc, m_stb, s_ack,
    input  s_cyc, s_stb, grant, grant_id, m_ack, m_err, timeout, busy
  );
endinterface

// File: rtl/wb_master_sched.sv
// Round-robin owner scheduler for four Wishbone masters: holds ownership for a
// whole cyc period, forwards cyc/stb/ack and aborts stalled transfers via a watchdog.
module wb_master_sched #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_WIDTH = 8
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  wb_master_sched_if.master bus
);
  localparam int unsigned N_M  = 4;
  localparam int unsigned ID_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [N_M-1:0]      grant_q;
  logic [N_M-1:0]      grant_nxt;
  logic [ID_W-1:0]     grant_id_q;
  logic [ID_W-1:0]     grant_id_nxt;
  logic [ID_W-1:0]     last_id_q;
  logic [ID_W-1:0]     last_id_nxt;
  logic [TO_WIDTH-1:0] wd_q;
  logic [TO_WIDTH-1:0] wd_nxt;
  logic [N_M-1:0]      err_q;
  logic [N_M-1:0]      err_nxt;
  logic                timeout_q;
  logic                timeout_nxt;
  logic                busy_q;
  logic                busy_nxt;

  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     cand;
  logic                pick_vld;
  logic                own_cyc;
  logic                own_stb;
  logic                stall;
  logic                wd_hit;
  logic                in_grant;

  assign own_cyc  = bus.m_cyc[grant_id_q];
  assign own_stb  = bus.m_stb[grant_id_q];
  assign stall    = own_stb & ~bus.s_ack;
  assign wd_hit   = (wd_q == TO_WIDTH'(TIMEOUT));
  assign in_grant = (state == GRANT);

  // Round-robin pick: first requester after the previous owner, wrapping mod 4.
  always_comb begin
    pick_id  = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= N_M; i++) begin
      cand = last_id_q + ID_W'(i);
      if (!pick_vld && bus.m_cyc[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus next values of every registered output and the watchdog.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    grant_id_nxt = grant_id_q;
    last_id_nxt  = last_id_q;
    wd_nxt       = wd_q;
    err_nxt      = '0;
    timeout_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt          = GRANT;
          grant_nxt          = '0;
          grant_nxt[pick_id] = 1'b1;
          grant_id_nxt       = pick_id;
          last_id_nxt        = pick_id;
          wd_nxt             = '0;
        end
      end

      GRANT: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          wd_nxt    = '0;
        end else if (wd_hit) begin
          // The err pulse is visible this cycle; the owner is cut off from the next one.
          state_nxt = ABORT;
        end else if (stall) begin
          if (wd_q != '1) begin
            wd_nxt = wd_q + TO_WIDTH'(1);
          end
          if (wd_q == TO_WIDTH'(TIMEOUT - 1)) begin
            err_nxt     = grant_q;
            timeout_nxt = 1'b1;
          end
        end else begin
          wd_nxt = '0;
        end
      end

      ABORT: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          wd_nxt    = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        wd_nxt    = '0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= ID_W'(N_M - 1);
      wd_q       <= '0;
      err_q      <= '0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      grant_q    <= grant_nxt;
      grant_id_q <= grant_id_nxt;
      last_id_q  <= last_id_nxt;
      wd_q       <= wd_nxt;
      err_q      <= err_nxt;
      timeout_q  <= timeout_nxt;
      busy_q     <= busy_nxt;
    end
  end

  // Forwarding is combinational and only while the owner is live (not aborted).
  assign bus.s_cyc    = in_grant & own_cyc;
  assign bus.s_stb    = in_grant & own_stb;
  assign bus.m_ack    = grant_q & {N_M{in_grant & bus.s_ack}};
  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.m_err    = err_q;
  assign bus.timeout  = timeout_q;
  assign bus.busy     = busy_q;

  a_grant_onehot: assert property (@(posedge wb_clk) disable iff (!wb_rst_n)
    $onehot0(grant_q));

  a_timeout_pulse: assert property (@(posedge wb_clk) disable iff (!wb_rst_n)
    timeout_q |=> !timeout_q);

endmodule

// File: tb/tb_wb_master_sched.sv
// Bench for wb_master_sched: directed scenarios plus random traffic, all checked
// every cycle against an owner/stall-count model of the scheduling rules.
module tb_wb_master_sched;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n;

  wb_master_sched_if bus();

  wb_master_sched #(.TIMEOUT(TO), .TO_WIDTH(3)) dut (
    .wb_clk  (clk),
    .wb_rst_n(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: who owns the bus, whether it was aborted, consecutive stall cycles.
  int own   = -1;
  int last  = 3;
  int gid   = 0;
  int stall = 0;
  bit abrt  = 1'b0;
  bit errp  = 1'b0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs only change just after a rising edge, so at the falling edge they equal
  // what the next rising edge samples: compare outputs first, then advance the model.
  initial begin : cmp
    logic [3:0] eg, ea, ee;
    logic       ec, es;
    bit         nerr;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        eg = '0; ea = '0; ee = '0; ec = 1'b0; es = 1'b0;
        if (own >= 0) begin
          eg[own] = 1'b1;
          if (!abrt) begin
            ec = bus.m_cyc[own];
            es = bus.m_stb[own];
            if (bus.s_ack) ea = eg;
          end
          if (errp) ee = eg;
        end
        check("grant",    bus.grant,    eg);
        check("grant_id", bus.grant_id, gid[1:0]);
        check("busy",     bus.busy,     own >= 0);
        check("s_cyc",    bus.s_cyc,    ec);
        check("s_stb",    bus.s_stb,    es);
        check("m_ack",    bus.m_ack,    ea);
        check("m_err",    bus.m_err,    ee);
        check("timeout",  bus.timeout,  errp);
      end

      if (!rst_n) begin
        own = -1; last = 3; gid = 0; stall = 0; abrt = 1'b0; errp = 1'b0;
      end else begin
        nerr = 1'b0;
        if (own < 0) begin
          for (int i = 1; i <= 4; i++)
            if (own < 0 && bus.m_cyc[(last + i) % 4]) own = (last + i) % 4;
          if (own >= 0) begin
            last = own; gid = own; stall = 0; abrt = 1'b0;
          end
        end else if (!bus.m_cyc[own]) begin
          own = -1; abrt = 1'b0; stall = 0;
        end else if (abrt) begin
          abrt = 1'b1;
        end else if (errp) begin
          abrt = 1'b1;
        end else if (bus.m_stb[own] && !bus.s_ack) begin
          stall++;
          if (stall == TO) nerr = 1'b1;
        end else begin
          stall = 0;
        end
        errp = nerr;
      end
    end
  end

  initial begin : drv
    logic [3:0] exp_g;
    logic [3:0] cy;

    rst_n = 1'b0;
    bus.m_cyc = 4'b1111;
    bus.m_stb = 4'b0000;
    bus.s_ack = 1'b0;

    // Reset held for three edges with every master requesting.
    repeat (3) begin
      tick();
      chk_en = 1'b1;
      check("rst_grant", bus.grant, 4'b0000);
      check("rst_busy",  bus.busy,  1'b0);
    end
    rst_n = 1'b1;
    tick();
    check("first_grant", bus.grant, 4'b0001);
    check("first_busy",  bus.busy,  1'b1);
    check("model_own0",  own,       0);

    // Rotation 0,1,2,3,0 with one idle cycle between owners.
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'(1 << (i % 4));
      check("rot_grant", bus.grant, exp_g);
      repeat (3) tick();
      bus.m_cyc[i % 4] = 1'b0;
      tick();
      check("rot_gap", bus.grant, 4'b0000);
      bus.m_cyc = (i == 4) ? 4'b0000 : 4'b1111;
      tick();
    end

    // Burst hold: m2 keeps the bus through 8 acks despite m0/m1 requesting.
    bus.m_cyc = 4'b0100;
    tick();
    check("burst_grant", bus.grant, 4'b0100);
    bus.m_stb = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      bus.s_ack = 1'b1;
      if (k == 3) bus.m_cyc = 4'b0111;
      #1;
      check("burst_ack",  bus.m_ack, 4'b0100);
      check("burst_hold", bus.grant, 4'b0100);
      tick();
    end
    bus.s_ack = 1'b0;
    bus.m_stb = 4'b0000;
    bus.m_cyc = 4'b0011;
    tick();
    check("burst_release", bus.grant, 4'b0000);
    tick();
    check("burst_next", bus.grant, 4'b0001);
    bus.m_cyc = 4'b0000;
    repeat (2) tick();

    // Watchdog: m1 stalls; err after four stall cycles, then ABORT.
    bus.m_cyc = 4'b0010;
    tick();
    check("wd_grant", bus.grant, 4'b0010);
    bus.m_stb = 4'b0010;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check("wd_err",  bus.m_err,   (t == 4) ? 4'b0010 : 4'b0000);
      check("wd_to",   bus.timeout, t == 4);
      check("wd_sstb", bus.s_stb,   1'b1);
    end
    tick();
    check("abort_sstb",  bus.s_stb, 1'b0);
    check("abort_err",   bus.m_err, 4'b0000);
    check("abort_busy",  bus.busy,  1'b1);
    check("abort_grant", bus.grant, 4'b0010);
    bus.s_ack = 1'b1;
    #1;
    check("abort_late_ack", bus.m_ack, 4'b0000);
    check("abort_scyc",     bus.s_cyc, 1'b0);
    bus.s_ack = 1'b0;
    bus.m_stb = 4'b0000;
    bus.m_cyc = 4'b0000;
    tick();
    check("abort_exit", bus.busy, 1'b0);

    // Ack on the last stall cycle before the limit wins and clears the count.
    bus.m_cyc = 4'b0100;
    tick();
    check("lim_grant0", bus.grant, 4'b0100);
    bus.m_stb = 4'b0100;
    repeat (3) tick();
    bus.s_ack = 1'b1;
    tick();
    bus.s_ack = 1'b0;
    check("lim_err",     bus.m_err,   4'b0000);
    check("lim_to",      bus.timeout, 1'b0);
    check("lim_busy",    bus.busy,    1'b1);
    check("model_stall", stall,       0);
    repeat (3) begin
      tick();
      check("lim_noerr", bus.m_err, 4'b0000);
    end
    bus.s_ack = 1'b1;
    tick();
    bus.s_ack = 1'b0;
    check("lim_grant", bus.grant, 4'b0100);
    bus.m_stb = 4'b0000;
    bus.m_cyc = 4'b0000;
    tick();
    check("lim_done", bus.grant, 4'b0000);

    // Reset while m3 is aborted: everything clears, then m3 is granted again.
    bus.m_cyc = 4'b1000;
    tick();
    check("rab_grant0", bus.grant, 4'b1000);
    bus.m_stb = 4'b1000;
    repeat (5) tick();
    check("rab_sstb", bus.s_stb, 1'b0);
    check("rab_busy", bus.busy,  1'b1);
    rst_n = 1'b0;
    tick();
    check("rab_rst_grant", bus.grant,    4'b0000);
    check("rab_rst_busy",  bus.busy,     1'b0);
    check("rab_rst_id",    bus.grant_id, 2'd0);
    check("rab_rst_err",   bus.m_err,    4'b0000);
    rst_n = 1'b1;
    tick();
    check("rab_regrant", bus.grant, 4'b1000);
    check("model_last",  last,      3);
    bus.m_stb = 4'b0000;
    bus.m_cyc = 4'b0000;
    tick();

    // Random traffic with ack-starved stretches and occasional reset pulses.
    for (int c = 0; c < 4000; c++) begin
      cy = bus.m_cyc;
      for (int m = 0; m < 4; m++) begin
        if (!cy[m]) cy[m] = ($urandom_range(0, 4) == 0);
        else if ($urandom_range(0, 9) == 0) cy[m] = 1'b0;
      end
      bus.m_cyc = cy;
      bus.m_stb = cy & 4'($urandom | $urandom);
      bus.s_ack = (((c / 150) % 3) == 2) ? 1'b0 : ($urandom_range(0, 1) == 1);
      rst_n     = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1;
    bus.m_cyc = 4'b0000;
    bus.m_stb = 4'b0000;
    bus.s_ack = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_master_sched.md
# wb_master_sched

Round-robin master scheduler for the shared Wishbone bus. It grants one of four masters ownership of the bus for a full `cyc` period, and gates that master's `cyc`/`stb` towards the address decoder. It routes `ack` back to the owner and aborts transfers that a slave never acknowledges, using a watchdog. It sits between the CPU/DMA/VGA/debug masters and the slave-side `wb_arb` decode, and replaces fixed-priority ownership with fair, starvation-free rotation.

## Interface
- `TIMEOUT`, 255: stall cycles (`stb` high, no `ack`) before an abort; legal range 1..2^TO_WIDTH-1.
- `TO_WIDTH`, 8: width of the watchdog counter.

- `wb_clk  in  1  bus clock`; all logic on rising edge.
- `wb_rst_n  in  1`: reset, synchronous and active-low (sampled on the `wb_clk` rising edge).
- `m_cyc_i  in  4`: per-master `cyc` request, bit n = master n.
- `m_stb_i  in  4`: per-master `stb`.
- `s_ack_i  in  1`: `ack` from the slave side of the bus.
- `s_cyc_o  out  1`: `cyc` of the current owner; 0 when there is no owner or in ABORT.
- `s_stb_o  out  1`: `stb` of the current owner; 0 when there is no owner or in ABORT.
- `grant_o  out  4`: one-hot owner, registered; all zero when no owner.
- `grant_id_o  out  2`: binary index of the owner; drives the address/data mux select.
- `m_ack_o  out  4`: `ack` returned to the owner only.
- `m_err_o  out  4`: one-cycle `err` pulse to the owner on a watchdog abort.
- `timeout_o  out  1`: one-cycle pulse when any abort occurs; goes to the interrupt controller.
- `busy_o  out  1`: high in GRANT or ABORT.

## Operation
States: IDLE, GRANT, ABORT.

**IDLE**
- If no `m_cyc_i` bit is set, stay in IDLE.
- Otherwise select the first requesting master scanning `last_id+1, last_id+2, …` (mod 4).
- Register `grant_o`, `grant_id_o` and `last_id` from that selection, clear the watchdog, and go to GRANT.

**GRANT**
- `s_cyc_o = m_cyc_i[grant_id_o]` and `s_stb_o = m_stb_i[grant_id_o]`, both combinational.
- `m_ack_o = grant_o & {4{s_ack_i}}`, combinational.
- Ownership is held for the whole owner's `cyc` period, bursts included. Other requests cannot preempt it.
- When the owner's `cyc` is low at a clock edge: go to IDLE and clear `grant_o`.

**Watchdog** (active in GRANT only)
- Increments each cycle the owner has `stb` high and `s_ack_i` low.
- Clears when `s_ack_i` is high or `stb` is low.
- Saturates; never wraps.
- When the count reaches `TIMEOUT` with `stb` still high and no `ack`: go to ABORT. For that one cycle, `m_err_o[grant_id_o]` and `timeout_o` pulse high.
- If `ack` arrives in the same cycle the count would reach `TIMEOUT`, the `ack` wins: no abort, counter clears.

**ABORT**
- `s_cyc_o`, `s_stb_o` and `m_ack_o` are forced to 0.
- `grant_o` is held so the mux stays stable.
- Stay in ABORT until the owner drops `cyc`, then go to IDLE.
- Ignore a late `s_ack_i` from the slave.

**Boundary cases**
- Owner drops `cyc` while other masters are requesting: there is exactly one IDLE cycle before the next grant. That next grant uses `last_id` rotation, so the same master cannot win twice in a row while others are waiting.
- A master raises `cyc` in the same cycle the owner drops it: it takes part in the next IDLE arbitration.
- Reset asserted mid-transfer: the next edge forces IDLE and clears every output, even during ABORT.

## Timing
- Reset values:
  - state = IDLE, `last_id` = 3 (so master 0 has first priority).
  - `grant_o` = 0, `grant_id_o` = 0, watchdog = 0.
  - `s_cyc_o`, `s_stb_o`, `m_ack_o`, `m_err_o`, `timeout_o`, `busy_o` = 0.
- Grant latency: a request sampled at edge k in IDLE gives `grant_o` valid after edge k, so `s_cyc_o` rises in cycle k+1.
- Release: owner's `cyc` low at edge k gives `grant_o` = 0 after edge k. The next grant is valid after edge k+1.
- `ack`/`stb` forwarding adds 0 cycles.
- Abort: with `stb` continuously high and no `ack` from cycle j, the `err` pulse occurs in cycle j+TIMEOUT and `s_stb_o` falls in cycle j+TIMEOUT+1.
- `m_err_o` and `timeout_o` are registered, exactly one cycle wide.

## Test plan
- **Reset / first grant:** reset low for 3 cycles, then `m_cyc_i` = 4'b1111 → `grant_o` = 4'b0001 one cycle later and `busy_o` = 1; every output is 0 during reset.
- **Rotation:** all four masters hold `cyc` for 4 cycles each, then drop it and re-request → grant sequence 0,1,2,3,0, with exactly one idle cycle between grants.
- **Burst hold:** m2 owns the bus with 8 `ack`s; m0 and m1 request mid-burst → `grant_o` stays at 4'b0100 until m2 drops `cyc`, then the grant goes to m3 only if m3 is requesting, otherwise to m0. Each `ack` appears only on `m_ack_o[2]`.
- **Watchdog:** `TIMEOUT` = 4; m1 holds `stb` with no `ack` → `m_err_o` = 4'b0010 and `timeout_o` pulse on the 4th stall cycle. `s_stb_o` is 0 afterwards, and a late `s_ack_i` is not forwarded. m1 drops `cyc` → IDLE.
- **Ack at limit:** `TIMEOUT` = 4, `ack` arrives on the 4th stall cycle → no `err`, counter clears, transfer completes normally.
- **Reset mid-ABORT:** reset pulses low while in ABORT with m3 still holding `cyc` → all outputs 0 after the edge. After reset is released, m3 is re-granted, because `last_id` has been reset to 3 and no other master is requesting.
